// File: rtl/vending_pkg.sv
// Shared types and constants for the coin-operated vending controller.
package vending_pkg;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      VEND    = 2'd1,
      CHANGE  = 2'd2
   } state_e;

   localparam logic [2:0] COIN5_VAL  = 3'd1;
   localparam logic [2:0] COIN10_VAL = 3'd2;
   localparam logic [2:0] COIN20_VAL = 3'd4;

   localparam int DEF_PRICE      = 3;
   localparam int DEF_MAX_CREDIT = 15;
   localparam int DEF_CREDIT_W   = 5;

endpackage

// File: rtl/vending_if.sv
// Coin inputs and dispense/refund outputs of the vending controller.
interface vending_if
   import vending_pkg::*;
#(
   parameter int CREDIT_W = DEF_CREDIT_W
);
   logic                coin5;
   logic                coin10;
   logic                coin20;
   logic                cancel;
   logic                vend;
   logic                back5;
   logic                refuse;
   logic                busy;
   logic [CREDIT_W-1:0] credit;

   modport master (
      output coin5, coin10, coin20, cancel,
      input  vend, back5, refuse, busy, credit
   );

   modport slave (
      input  coin5, coin10, coin20, cancel,
      output vend, back5, refuse, busy, credit
   );
endinterface

// File: rtl/coin_decode.sv
// Combinational coin check: one-hot coin inputs map to a credit value,
// several coins at once are flagged as multi.
module coin_decode
   import vending_pkg::*;
(
   input  logic       coin5,
   input  logic       coin10,
   input  logic       coin20,
   output logic       valid,
   output logic       multi,
   output logic [2:0] value
);

   always_comb begin
      // NOTE: defaults first so every path assigns every output (no latch).
      valid = 1'b0;
      multi = 1'b0;
      value = '0;
      unique case ({coin20, coin10, coin5})
         3'b000: ;
         3'b001: begin valid = 1'b1; value = COIN5_VAL;  end
         3'b010: begin valid = 1'b1; value = COIN10_VAL; end
         3'b100: begin valid = 1'b1; value = COIN20_VAL; end
         default: multi = 1'b1;
      endcase
   end

endmodule

// File: rtl/vending_ctrl.sv
// Vending controller: collects coins into credit, vends at PRICE and pays
// change (or a cancel refund) one 5-coin per cycle.
module vending_ctrl
   import vending_pkg::*;
#(
   parameter int PRICE      = DEF_PRICE,
   parameter int MAX_CREDIT = DEF_MAX_CREDIT,
   parameter int CREDIT_W   = DEF_CREDIT_W
)(
   input  logic      clk,
   input  logic      reset,
   vending_if.slave  bus
);

   localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
   localparam logic [CREDIT_W:0]   PRICE_W = (CREDIT_W+1)'(PRICE);
   localparam logic [CREDIT_W:0]   MAX_W   = (CREDIT_W+1)'(MAX_CREDIT);

   state_e              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic                refuse_q, refuse_d;

   logic                coin_valid, coin_multi, any_coin, fits;
   logic [2:0]          coin_value;
   logic [CREDIT_W:0]   sum;

   coin_decode u_coin_decode (
      .coin5  (bus.coin5),
      .coin10 (bus.coin10),
      .coin20 (bus.coin20),
      .valid  (coin_valid),
      .multi  (coin_multi),
      .value  (coin_value)
   );

   // One extra bit so the overflow test cannot wrap.
   assign any_coin = coin_valid | coin_multi;
   assign sum      = {1'b0, credit_q} + (CREDIT_W+1)'(coin_value);
   assign fits     = (sum <= MAX_W);

   always_comb begin
      state_d  = state_q;
      credit_d = credit_q;
      refuse_d = any_coin;
      unique case (state_q)
         COLLECT: begin
            refuse_d = any_coin & ~(coin_valid & fits & ~bus.cancel);
            if (bus.cancel) begin
               if (credit_q != '0) state_d = CHANGE;
            end else if (coin_valid && fits) begin
               credit_d = sum[CREDIT_W-1:0];
               if (sum >= PRICE_W) state_d = VEND;
            end
         end
         VEND: begin
            credit_d = credit_q - PRICE_C;
            state_d  = (credit_q == PRICE_C) ? COLLECT : CHANGE;
         end
         CHANGE: begin
            credit_d = (credit_q == '0) ? '0 : credit_q - 1'b1;
            if (credit_q <= CREDIT_W'(1)) state_d = COLLECT;
         end
         default: begin
            state_d  = COLLECT;
            credit_d = '0;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= COLLECT;
         credit_q <= '0;
         refuse_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         credit_q <= credit_d;
         refuse_q <= refuse_d;
      end
   end

   assign bus.vend   = (state_q == VEND);
   assign bus.back5  = (state_q == CHANGE);
   assign bus.busy   = (state_q != COLLECT);
   assign bus.refuse = refuse_q;
   assign bus.credit = credit_q;

endmodule
